// File: rtl/data_mem_pkg.sv
// rtl/data_mem_pkg.sv - shared encodings and helpers for the byte-addressable data memory
//
// Contents:
//   mem_size_e  : access size encoding carried on MemSize
//   mem_state_e : init-sweep / ready states of the memory controller
//   off_w()     : byte-offset width for a given word width
//   size_mask() : right-aligned bit mask covering one access of the given size
package data_mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'd0,
        SZ_HALF  = 2'd1,
        SZ_WORD  = 2'd2,
        SZ_DWORD = 2'd3
    } mem_size_e;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } mem_state_e;

    function automatic int off_w(input int data_w);
        return $clog2(data_w / 8);
    endfunction

    // Callers truncate to their word width; a dword mask on a 32-bit word
    // simply becomes all ones, and that size is rejected upstream anyway.
    function automatic logic [63:0] size_mask(input logic [1:0] size);
        logic [63:0] m;
        case (size)
            SZ_BYTE: m = 64'h0000_0000_0000_00ff;
            SZ_HALF: m = 64'h0000_0000_0000_ffff;
            SZ_WORD: m = 64'h0000_0000_ffff_ffff;
            default: m = 64'hffff_ffff_ffff_ffff;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// rtl/mem_load_align.sv - combinational load alignment and sign/zero extension
//
// Ports:
//   word        in  DATA_W  full memory word holding the addressed bytes
//   offset      in  OFF_W   byte offset of the access within the word
//   size        in  2       access size (mem_size_e encoding)
//   is_unsigned in  1       1 = zero-extend, 0 = sign-extend
//   load_value  out DATA_W  selected bytes, right-aligned and extended
module mem_load_align
    import data_mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OFF_W  = off_w(DATA_W)
) (
    input  logic [DATA_W-1:0] word,
    input  logic [OFF_W-1:0]  offset,
    input  logic [1:0]        size,
    input  logic              is_unsigned,
    output logic [DATA_W-1:0] load_value
);

    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] low_mask;
    logic [DATA_W-1:0] msb_mask;
    logic              sign;

    always_comb begin
        shifted  = word >> {offset, 3'b000};
        low_mask = DATA_W'(size_mask(size));
        // Isolates the top bit of the access so the sign can be picked out
        // without a variable bit index.
        msb_mask = low_mask & ~(low_mask >> 1);
        sign     = (|(shifted & msb_mask)) & ~is_unsigned;
        load_value = (shifted & low_mask) | (sign ? ~low_mask : '0);
    end

endmodule

// File: rtl/byte_data_memory.sv
// rtl/byte_data_memory.sv - byte-addressable MEM-stage data memory with init sweep
//
// Ports:
//   clk         in  1       clock, rising edge
//   reset       in  1       asynchronous active-low reset
//   MemAddr     in  ADDR_W  byte address
//   Write_Data  in  DATA_W  store data, right-aligned
//   MemRead     in  1       load request
//   MemWrite    in  1       store request
//   MemSize     in  2       0=byte 1=half 2=word 3=dword (dword only when DATA_W=64)
//   MemUnsigned in  1       1 = zero-extend load, 0 = sign-extend
//   Read_Data   out DATA_W  registered load result
//   Read_Valid  out 1       pulse: Read_Data updated
//   Busy        out 1       init sweep in progress, requests ignored
//   Misaligned  out 1       pulse: previous request rejected
module byte_data_memory
    import data_mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] MemAddr,
    input  logic [DATA_W-1:0] Write_Data,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [1:0]        MemSize,
    input  logic              MemUnsigned,
    output logic [DATA_W-1:0] Read_Data,
    output logic              Read_Valid,
    output logic              Busy,
    output logic              Misaligned
);

    localparam int OFF_W = off_w(DATA_W);
    localparam int IDX_W = ADDR_W - OFF_W;
    localparam int DEPTH = 2 ** IDX_W;

    logic [DATA_W-1:0] mem [DEPTH];

    mem_state_e        state_q, state_d;
    logic [IDX_W-1:0]  sweep_q, sweep_d;

    logic [IDX_W-1:0]  word_idx;
    logic [OFF_W-1:0]  offset;
    logic [OFF_W-1:0]  align_mask;
    logic              size_ok;
    logic              req;
    logic              legal;
    logic              do_load;
    logic              do_store;
    logic [DATA_W-1:0] cur_word;
    logic [DATA_W-1:0] lane_mask;
    logic [DATA_W-1:0] store_word;
    logic [DATA_W-1:0] load_value;

    logic              mem_we;
    logic [IDX_W-1:0]  mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    // Request decode and byte-lane merge. The current word is read
    // combinationally before the edge, which gives read-first behaviour when
    // a load and a store arrive together.
    always_comb begin
        word_idx   = MemAddr[ADDR_W-1:OFF_W];
        offset     = MemAddr[OFF_W-1:0];
        align_mask = OFF_W'((32'd1 << MemSize) - 32'd1);
        size_ok    = (MemSize != SZ_DWORD) || (DATA_W == 64);
        req        = (state_q == ST_READY) && (MemRead || MemWrite);
        legal      = size_ok && ((offset & align_mask) == '0);
        do_load    = req && legal && MemRead;
        do_store   = req && legal && MemWrite;
        cur_word   = mem[word_idx];
        lane_mask  = DATA_W'(size_mask(MemSize)) << {offset, 3'b000};
        store_word = (cur_word & ~lane_mask)
                   | ((Write_Data << {offset, 3'b000}) & lane_mask);
    end

    mem_load_align #(
        .DATA_W (DATA_W),
        .OFF_W  (OFF_W)
    ) u_load_align (
        .word        (cur_word),
        .offset      (offset),
        .size        (MemSize),
        .is_unsigned (MemUnsigned),
        .load_value  (load_value)
    );

    // Next-state logic: the sweep owns the write port until every word has
    // been cleared; after that only legal stores write.
    always_comb begin
        state_d   = state_q;
        sweep_d   = sweep_q;
        mem_we    = 1'b0;
        mem_waddr = word_idx;
        mem_wdata = store_word;
        case (state_q)
            ST_INIT: begin
                mem_we    = 1'b1;
                mem_waddr = sweep_q;
                mem_wdata = '0;
                sweep_d   = sweep_q + IDX_W'(1);
                if (&sweep_q) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                mem_we = do_store;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_INIT;
            sweep_q    <= '0;
            Read_Data  <= '0;
            Read_Valid <= 1'b0;
            Misaligned <= 1'b0;
        end else begin
            state_q    <= state_d;
            sweep_q    <= sweep_d;
            Read_Valid <= do_load;
            Misaligned <= req && !legal;
            if (do_load) begin
                Read_Data <= load_value;
            end
        end
    end

    // Storage carries no reset; the init sweep is what clears it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign Busy = (state_q == ST_INIT);

endmodule

// File: doc/byte_data_memory.md
# byte_data_memory

Parametrised, byte-addressable data memory for the pipeline's MEM stage; successor to the fixed 32-bit word memory. Adds byte/half/word(/dword) accesses with sign or zero extension, byte-lane write merging, misalignment detection, a registered read port with a valid strobe, and a self-clearing init sweep after reset.

## Interface
- DATA_W, 32, word width in bits; 32 or 64.
- ADDR_W, 8, byte-address width; depth = 2**(ADDR_W-OFF_W) words, OFF_W = log2(DATA_W/8).

- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset; one clock domain.
- MemAddr  in  ADDR_W  byte address.
- Write_Data  in  DATA_W  store data, right-aligned (bits [8*size_bytes-1:0] used).
- MemRead  in  1  load request.
- MemWrite  in  1  store request.
- MemSize  in  2  0=byte, 1=half, 2=word, 3=dword (legal only when DATA_W=64).
- MemUnsigned  in  1  1=zero-extend load, 0=sign-extend.
- Read_Data  out  DATA_W  registered load result.
- Read_Valid  out  1  one-cycle pulse: Read_Data updated.
- Busy  out  1  init sweep in progress; requests ignored.
- Misaligned  out  1  one-cycle pulse: previous request rejected.

## Operation
- FSM states: INIT, READY.
- reset low: state=INIT, sweep index=0, Read_Data=0, Read_Valid=0, Misaligned=0, Busy=1.
- INIT: each cycle write zero to word[index], index++; after word DEPTH-1 go to READY, Busy=0 from the next cycle. Takes DEPTH cycles. MemRead/MemWrite ignored (no pulses).
- READY, request accepted each cycle MemRead or MemWrite is high.
- Word index = MemAddr[ADDR_W-1:OFF_W]; offset = MemAddr[OFF_W-1:0].
- Alignment: offset must be a multiple of 2**MemSize bytes; MemSize=3 with DATA_W=32 is also illegal. Illegal request: no memory change, Read_Valid stays 0, Misaligned pulses next cycle, Read_Data holds.
- Store: lanes offset..offset+2**MemSize-1 replaced by the low bytes of Write_Data; other lanes unchanged.
- Load: select the bytes at offset, right-align, extend to DATA_W per MemUnsigned; register into Read_Data, Read_Valid=1 next cycle.
- MemRead and MemWrite together, same or different address: store is performed; load returns pre-store contents (read-first).
- Read_Data holds its value when no load completes.
- Address wrap: none; every ADDR_W value maps to a word.

## Timing
- Load latency 1: request at edge N, Read_Data/Read_Valid valid after edge N+1.
- Store visible to a load issued in the next cycle (back-to-back store then load returns new data).
- Misaligned pulse aligned with where Read_Valid would have been.
- reset asserted mid-access or mid-sweep: immediate return to INIT, outputs to reset values, sweep restarts at 0; an in-flight load produces no Read_Valid.
- Release of reset takes effect at the next rising edge of clk.

## Structure
- Package data_mem_pkg: MemSize encodings (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DWORD), FSM state encoding, OFF_W helper function.
- Sub-module mem_load_align (combinational): word + offset + size + unsigned → extended load value; reused by the writeback path later.
- Storage: single array of DATA_W-bit words, byte-lane merge in the write path.

## Test plan
- Reset then idle: Busy=1 for exactly 64 cycles (DATA_W=32, ADDR_W=8), then 0; load word at 0x40 → Read_Data=0x00000000, Read_Valid pulse.
- Store word 0xDEADBEEF at 0x40, store byte 0x7F at 0x41; load word 0x40 → 0xDEAD7FEF.
- Load byte 0x43 signed → 0xFFFFFFDE; unsigned → 0x000000DE; load half 0x42 signed → 0xFFFFDEAD.
- Store half at 0x41 and load word at 0x42 → Misaligned pulse each, memory unchanged, Read_Valid 0; MemSize=3 at 0x40 → Misaligned.
- MemRead+MemWrite at 0x80 with 0x12345678 over 0 → Read_Data=0x00000000; next load 0x80 → 0x12345678.
- reset low during sweep and during a pending load → no Read_Valid, Busy stays 1 for a full 64-cycle restart, prior data cleared to 0.
